cnt60_down: RTL and testbench

- Modulo-60 BCD down-counter; the decrementing counterpart of the team's mod-60 up-counter. Used for countdown-timer minutes/seconds digits.
- Loadable preset; counts down on EN (cascade or tick) or DEC (manual button).
- Borrow output BR cascades into the next-higher stage, the same way the up-counter's carry does.

---
 rtl/cnt60_pkg.sv | 15 +
 rtl/bcd_digit_down.sv | 37 +++
 rtl/cnt60_down.sv | 92 +++++++++
 tb/tb_cnt60_down.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cnt60_pkg.sv
// Shared widths, default digit maxima and the digit-pair type for the
// mod-60 BCD counter family.
package cnt60_pkg;

  localparam int HI_W     = 3;
  localparam int LO_W     = 4;
  localparam int LO_MAX_D = 9;
  localparam int HI_MAX_D = 5;

  typedef struct packed {
    logic [HI_W-1:0] hi;
    logic [LO_W-1:0] lo;
  } digit_pair_t;

endpackage

// File: rtl/bcd_digit_down.sv
// One loadable down-counting digit that wraps from 0 to MAX; presets above
// MAX clamp to MAX.
module bcd_digit_down #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         dec_en,
  output logic [W-1:0] q,
  output logic         at_zero
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] load_v;

  assign load_v  = (d > MAX_V) ? MAX_V : d;
  assign at_zero = (q == '0);

  // Priority clear > load > decrement; a decrement at 0 wraps to MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= load_v;
    end else if (dec_en) begin
      q <= at_zero ? MAX_V : (q - W'(1));
    end
  end

endmodule

// File: rtl/cnt60_down.sv
// Modulo-60 BCD down-counter with preset load and cascadable borrow.
// Optional macro CNT60_DOWN_STOP_AT_ZERO_EN: hold at 00 and raise sticky DONE.
module cnt60_down
  import cnt60_pkg::*;
#(
  parameter int LO_MAX = LO_MAX_D,
  parameter int HI_MAX = HI_MAX_D
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CLR,
  input  logic            LD,
  input  logic [HI_W-1:0] DH,
  input  logic [LO_W-1:0] DL,
  input  logic            EN,
  input  logic            DEC,
  output logic [HI_W-1:0] QH,
  output logic [LO_W-1:0] QL,
  output logic            BR,
  output logic            ZERO
`ifdef CNT60_DOWN_STOP_AT_ZERO_EN
  ,
  output logic            DONE
`endif
);

  digit_pair_t cnt;
  logic        lo_zero;
  logic        hi_zero;
  logic        step_req;
  logic        ctrl_busy;
  logic        step;

  assign step_req  = EN | DEC;
  assign ctrl_busy = CLR | LD;

`ifdef CNT60_DOWN_STOP_AT_ZERO_EN
  logic done_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      done_q <= 1'b0;
    end else if (ctrl_busy) begin
      done_q <= 1'b0;
    end else if (step_req && ZERO) begin
      done_q <= 1'b1;
    end
  end

  // At 00 the step is suppressed so the count parks instead of wrapping.
  assign step = step_req & ~ZERO;
  assign BR   = EN & ZERO & ~ctrl_busy & ~done_q;
  assign DONE = done_q;
`else
  assign step = step_req;
  assign BR   = EN & ZERO & ~ctrl_busy;
`endif

  bcd_digit_down #(
    .W   (LO_W),
    .MAX (LO_MAX)
  ) u_lo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (CLR),
    .ld      (LD),
    .d       (DL),
    .dec_en  (step),
    .q       (cnt.lo),
    .at_zero (lo_zero)
  );

  // The high digit only moves when the low digit is about to wrap.
  bcd_digit_down #(
    .W   (HI_W),
    .MAX (HI_MAX)
  ) u_hi (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (CLR),
    .ld      (LD),
    .d       (DH),
    .dec_en  (step & lo_zero),
    .q       (cnt.hi),
    .at_zero (hi_zero)
  );

  assign QH   = cnt.hi;
  assign QL   = cnt.lo;
  assign ZERO = lo_zero & hi_zero;

endmodule

// File: tb/tb_cnt60_down.sv
// Self-checking bench for cnt60_down: default 5:9 instance plus a 2:5 instance,
// checked with a vector table, hand sequences and a randomized model run.
module tb_cnt60_down;

  logic       CLK;
  logic       RST_N;
  logic       CLR;
  logic       LD;
  logic [2:0] DH;
  logic [3:0] DL;
  logic       EN;
  logic       DEC;
  logic [2:0] qh1;
  logic [3:0] ql1;
  logic       br1;
  logic       zero1;
  logic [2:0] qh2;
  logic [3:0] ql2;
  logic       br2;
  logic       zero2;

  int errors;
  int checks;
  int v1;
  int v2;
  logic last_br;

  cnt60_down dut1 (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LD(LD), .DH(DH), .DL(DL),
    .EN(EN), .DEC(DEC), .QH(qh1), .QL(ql1), .BR(br1), .ZERO(zero1)
  );

  cnt60_down #(.LO_MAX(5), .HI_MAX(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LD(LD), .DH(DH), .DL(DL),
    .EN(EN), .DEC(DEC), .QH(qh2), .QL(ql2), .BR(br2), .ZERO(zero2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       clr;
    logic       ld;
    logic [2:0] dh;
    logic [3:0] dl;
    logic       en;
    logic       dec;
    logic       exp_br;
    logic [2:0] exp_qh;
    logic [3:0] exp_ql;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic l, logic [2:0] h, logic [3:0] d,
                              logic e, logic de, logic b, logic [2:0] qh,
                              logic [3:0] ql);
    vec_t r;
    r.clr = c; r.ld = l; r.dh = h; r.dl = d; r.en = e; r.dec = de;
    r.exp_br = b; r.exp_qh = qh; r.exp_ql = ql;
    return r;
  endfunction

  // The count is treated as one number hi*(lmax+1)+lo, modulo the full range.
  function automatic int mstep(int v, int hmax, int lmax, logic c, logic l,
                               logic [2:0] h, logic [3:0] d, logic e, logic de);
    int m;
    int hh;
    int ll;
    m = (hmax + 1) * (lmax + 1);
    if (c) return 0;
    if (l) begin
      hh = (int'(h) > hmax) ? hmax : int'(h);
      ll = (int'(d) > lmax) ? lmax : int'(d);
      return hh * (lmax + 1) + ll;
    end
    if (e || de) return (v + m - 1) % m;
    return v;
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge; checks combinational outputs, then the
  // registered state after the next edge.
  task automatic apply_stimulus(input logic c, input logic l, input logic [2:0] h,
                                input logic [3:0] d, input logic e, input logic de);
    CLR = c; LD = l; DH = h; DL = d; EN = e; DEC = de;
    #1;
    check_output("br1", br1, int'(e && v1 == 0 && !c && !l));
    check_output("zero1", zero1, int'(v1 == 0));
    check_output("br2", br2, int'(e && v2 == 0 && !c && !l));
    check_output("zero2", zero2, int'(v2 == 0));
    last_br = br1;
    v1 = mstep(v1, 5, 9, c, l, h, d, e, de);
    v2 = mstep(v2, 2, 5, c, l, h, d, e, de);
    @(posedge CLK);
    #1;
    check_output("qh1", qh1, v1 / 10);
    check_output("ql1", ql1, v1 % 10);
    check_output("qh2", qh2, v2 / 6);
    check_output("ql2", ql2, v2 % 6);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    v1 = 0;
    v2 = 0;
    last_br = 1'b0;
    RST_N = 1'b0;
    CLR = 0; LD = 0; DH = 0; DL = 0; EN = 0; DEC = 0;
    repeat (2) @(posedge CLK);
    #1;
    check_output("rst_qh", qh1, 0);
    check_output("rst_ql", ql1, 0);
    check_output("rst_zero", zero1, 1);
    check_output("rst_br", br1, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Reset asserted mid-count at 3:7, away from the clock edge
    apply_stimulus(0, 1, 3'd3, 4'd7, 0, 0);
    check_output("pre_rst_qh", qh1, 3);
    check_output("pre_rst_ql", ql1, 7);
    EN = 0; LD = 0;
    #2;
    RST_N = 1'b0;
    #1;
    v1 = 0;
    v2 = 0;
    check_output("async_rst_qh", qh1, 0);
    check_output("async_rst_ql", ql1, 0);
    check_output("async_rst_zero", zero1, 1);
    check_output("async_rst_br", br1, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    apply_stimulus(0, 0, 3'd0, 4'd0, 1, 0);
    check_output("rst_wrap_br", last_br, 1);
    check_output("rst_wrap_qh", qh1, 5);
    check_output("rst_wrap_ql", ql1, 9);
    check_output("p2_wrap_qh", qh2, 2);
    check_output("p2_wrap_ql", ql2, 5);

    //              clr ld  dh    dl     en dec br  qh    ql
    vecs.push_back(mk(0, 1, 3'd1, 4'd0,  0, 0,  0, 3'd1, 4'd0));
    vecs.push_back(mk(0, 0, 3'd0, 4'd0,  1, 0,  0, 3'd0, 4'd9));
    vecs.push_back(mk(0, 0, 3'd0, 4'd0,  1, 0,  0, 3'd0, 4'd8));
    vecs.push_back(mk(0, 0, 3'd0, 4'd0,  1, 0,  0, 3'd0, 4'd7));
    vecs.push_back(mk(0, 0, 3'd0, 4'd0,  0, 0,  0, 3'd0, 4'd7));
    vecs.push_back(mk(0, 1, 3'd2, 4'd4,  0, 0,  0, 3'd2, 4'd4));
    vecs.push_back(mk(1, 1, 3'd2, 4'd4,  1, 0,  0, 3'd0, 4'd0));
    vecs.push_back(mk(0, 0, 3'd0, 4'd0,  1, 0,  1, 3'd5, 4'd9));
    vecs.push_back(mk(0, 1, 3'd0, 4'd0,  0, 0,  0, 3'd0, 4'd0));
    vecs.push_back(mk(0, 0, 3'd0, 4'd0,  0, 1,  0, 3'd5, 4'd9));
    vecs.push_back(mk(0, 1, 3'd0, 4'd0,  0, 0,  0, 3'd0, 4'd0));
    vecs.push_back(mk(0, 1, 3'd4, 4'd2,  1, 0,  0, 3'd4, 4'd2));
    vecs.push_back(mk(0, 1, 3'd7, 4'd12, 0, 0,  0, 3'd5, 4'd9));
    vecs.push_back(mk(0, 0, 3'd0, 4'd0,  1, 1,  0, 3'd5, 4'd8));
    vecs.push_back(mk(0, 1, 3'd0, 4'd0,  0, 0,  0, 3'd0, 4'd0));
    vecs.push_back(mk(0, 0, 3'd0, 4'd0,  1, 1,  1, 3'd5, 4'd9));
    vecs.push_back(mk(0, 1, 3'd0, 4'd15, 0, 0,  0, 3'd0, 4'd9));
    vecs.push_back(mk(0, 0, 3'd0, 4'd0,  0, 1,  0, 3'd0, 4'd8));
    vecs.push_back(mk(0, 1, 3'd3, 4'd0,  0, 0,  0, 3'd3, 4'd0));
    vecs.push_back(mk(0, 0, 3'd0, 4'd0,  1, 0,  0, 3'd2, 4'd9));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].clr, vecs[i].ld, vecs[i].dh, vecs[i].dl,
                     vecs[i].en, vecs[i].dec);
      check_output($sformatf("vec%0d_br", i), last_br, vecs[i].exp_br);
      check_output($sformatf("vec%0d_qh", i), qh1, vecs[i].exp_qh);
      check_output($sformatf("vec%0d_ql", i), ql1, vecs[i].exp_ql);
    end

    for (int n = 0; n < 400; n++) begin
      apply_stimulus($urandom_range(0, 15) == 0,
                     $urandom_range(0, 7) == 0,
                     3'($urandom_range(0, 7)),
                     4'($urandom_range(0, 15)),
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
